// File: rtl/div_share_ctrl.sv
// -----------------------------------------------------------------------------
// div_share_ctrl
//
// Shares one sequential divider core between two clients. Requests are
// arbitrated round-robin in IDLE. The granted client's operands are latched
// onto the core buses, and the core's start/ready handshake is sequenced.
// The result is then returned with a one-cycle done pulse to that client.
// A zero divisor is answered directly without starting the core. An
// operation whose core does not come back in time is aborted with err=1.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req0/req1             level requests, held by the client until its done
//   dividend0/1,divisor0/1 client operands, stable while the request is held
//   done0/done1           one-cycle pulse, result valid for that client
//   q_out, r_out, err     registered result, held until the next done
//   busy                  high whenever the controller is not in IDLE
//   div_start             one-cycle start pulse to the divider core
//   div_dbus, div_mbus    dividend/divisor to the core, latched at grant
//   div_q, div_r          core quotient/remainder
//   div_ready             core ready: low while computing, high when idle/done
// -----------------------------------------------------------------------------
module div_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             err,
    output logic             busy,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dbus,
    output logic [WIDTH-1:0] div_mbus,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } state_e;

    // The counter is cleared in START, so in the k-th wait cycle after the
    // start pulse it holds k-1. Aborting when it holds TIMEOUT-2 places the
    // DONE cycle exactly TIMEOUT cycles after div_start.
    localparam logic [CNT_W-1:0] ABORT_AT = CNT_W'(TIMEOUT - 2);

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dbus_q, dbus_d;
    logic [WIDTH-1:0] mbus_q, mbus_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             err_q, err_d;
    logic             pick;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        dbus_d       = dbus_q;
        mbus_d       = mbus_q;
        q_d          = q_q;
        r_d          = r_q;
        err_d        = err_q;
        div_start    = 1'b0;
        done0        = 1'b0;
        done1        = 1'b0;

        // Round-robin only matters when both ask; a lone requester always wins.
        if (req0 && req1) begin
            pick = ~last_grant_q;
        end else begin
            pick = req1;
        end

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    dbus_d       = pick ? dividend1 : dividend0;
                    mbus_d       = pick ? divisor1 : divisor0;
                    state_d      = (mbus_d == '0) ? S_ZERO : S_START;
                end
            end

            S_ZERO: begin
                q_d     = '1;
                r_d     = dbus_q;
                err_d   = 1'b1;
                state_d = S_DONE;
            end

            S_START: begin
                div_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout takes priority here: an acknowledge on the abort
                // cycle would otherwise overrun the time limit.
                if (cnt_q == ABORT_AT) begin
                    q_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!div_ready) begin
                    state_d = S_WAIT_HIGH;
                end
            end

            S_WAIT_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the abort cycle is still in time.
                if (div_ready) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == ABORT_AT) begin
                    q_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done0   = ~grant_q;
                done1   = grant_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            dbus_q       <= '0;
            mbus_q       <= '0;
            q_q          <= '0;
            r_q          <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            dbus_q       <= dbus_d;
            mbus_q       <= mbus_d;
            q_q          <= q_d;
            r_q          <= r_d;
            err_q        <= err_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign div_dbus = dbus_q;
    assign div_mbus = mbus_q;
    assign q_out    = q_q;
    assign r_out    = r_q;
    assign err      = err_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_share_ctrl
//
// Self-checking bench for div_share_ctrl. A behavioural divider core answers
// start pulses after a random or fixed latency, or hangs on request. The
// expected results come from plain arithmetic on the client operands. The
// expected service order comes from a round-robin model that tracks only the
// last client served.
// -----------------------------------------------------------------------------
module tb_div_share_ctrl;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] dividend0, divisor0, dividend1, divisor1;
    logic             done0, done1;
    logic [WIDTH-1:0] q_out, r_out;
    logic             err, busy, div_start;
    logic [WIDTH-1:0] div_dbus, div_mbus;
    logic [WIDTH-1:0] div_q, div_r;
    logic             div_ready;

    int vectors     = 0;
    int miscompares = 0;

    div_share_ctrl #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .dividend0(dividend0),
        .divisor0 (divisor0),
        .req1     (req1),
        .dividend1(dividend1),
        .divisor1 (divisor1),
        .done0    (done0),
        .done1    (done1),
        .q_out    (q_out),
        .r_out    (r_out),
        .err      (err),
        .busy     (busy),
        .div_start(div_start),
        .div_dbus (div_dbus),
        .div_mbus (div_mbus),
        .div_q    (div_q),
        .div_r    (div_r),
        .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter, read at negedges only.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider core.
    bit hang      = 1'b0;
    int fixed_lat = 0;
    int lat_left;
    bit core_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ready <= 1'b1;
            div_q     <= '0;
            div_r     <= '0;
            lat_left  <= 0;
            core_run  <= 1'b0;
        end else if (div_start) begin
            div_ready <= 1'b0;
            core_run  <= 1'b1;
            lat_left  <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
        end else if (core_run && !hang) begin
            if (lat_left <= 1) begin
                div_ready <= 1'b1;
                core_run  <= 1'b0;
                div_q     <= (div_mbus != 0) ? div_dbus / div_mbus : '1;
                div_r     <= (div_mbus != 0) ? div_dbus % div_mbus : div_dbus;
            end else begin
                lat_left <= lat_left - 1;
            end
        end
    end

    // Observation state, updated only by tick() so the single stimulus
    // process never races with a separate monitor.
    int start_cnt = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int issue_cyc = 0;
    int model_last = 1;   // last client served; 1 so that client 0 wins first

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (div_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        if (done0 || done1) begin
            done_cyc = cyc;
            check("done_onehot", 32'(done0 & done1), 32'd0);
        end
    endtask

    // {err, quotient, remainder} as the client should see it.
    function automatic logic [32:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0) return {1'b1, 16'hFFFF, a};
        return {1'b0, 16'(a / b), 16'(a % b)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_done0"}, 32'(done0), 32'd0);
        check({tag, "_done1"}, 32'(done1), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(div_start), 32'd0);
        check({tag, "_q"}, 32'(q_out), 32'd0);
        check({tag, "_r"}, 32'(r_out), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_dbus"}, 32'(div_dbus), 32'd0);
        check({tag, "_mbus"}, 32'(div_mbus), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b1;
        #1;
        check_all_zero("rst");
        tick();
        tick();
        rst        = 1'b0;
        model_last = 1;
    endtask

    // Raise the selected requests, drop each at its done, check every result
    // and the service order. exp_timeout marks a hung core.
    task automatic run_op(input bit r0, input bit r1,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input bit exp_timeout);
        int          exp_order[$];
        int          idx;
        int          budget;
        int          starts0;
        int          nz;
        int          c;
        bit          pend0, pend1;
        logic [15:0] a, b;
        logic [32:0] e;

        tick();
        dividend0 = a0;
        divisor0  = b0;
        dividend1 = a1;
        divisor1  = b1;
        req0      = r0;
        req1      = r1;
        issue_cyc = cyc;
        starts0   = start_cnt;
        nz        = ((r0 && b0 != 0) ? 1 : 0) + ((r1 && b1 != 0) ? 1 : 0);

        if (r0 && r1) begin
            exp_order.push_back(1 - model_last);
            exp_order.push_back(model_last);
        end else if (r0) begin
            exp_order.push_back(0);
        end else begin
            exp_order.push_back(1);
        end
        model_last = exp_order[exp_order.size() - 1];

        pend0  = r0;
        pend1  = r1;
        idx    = 0;
        budget = 0;
        while ((pend0 || pend1) && budget < 400) begin
            tick();
            budget++;
            if (done0 || done1) begin
                c = done1 ? 1 : 0;
                if (idx < exp_order.size()) begin
                    check("order", 32'(c), 32'(exp_order[idx]));
                end else begin
                    check("extra_done", 32'(idx), 32'(exp_order.size()));
                end
                idx++;
                a = c ? a1 : a0;
                b = c ? b1 : b0;
                e = ref_div(a, b);
                if (exp_timeout && b != 0) e = {1'b1, 32'd0};
                check($sformatf("c%0d_q", c), 32'(q_out), 32'(e[31:16]));
                check($sformatf("c%0d_r", c), 32'(r_out), 32'(e[15:0]));
                check($sformatf("c%0d_err", c), 32'(err), 32'(e[32]));
                check("busy_at_done", 32'(busy), 32'd1);
                if (c == 0) begin
                    pend0 = 1'b0;
                    req0  = 1'b0;
                end else begin
                    pend1 = 1'b0;
                    req1  = 1'b0;
                end
            end
        end
        check("op_finished", 32'(pend0 || pend1), 32'd0);
        check("start_count", 32'(start_cnt - starts0), 32'(nz));
    endtask

    initial begin
        int          d0, d1, s0, n, budget, c, exp_c;
        bit          rr0, rr1;
        logic [15:0] ra0, rb0, ra1, rb1;

        rst       = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        dividend0 = '0;
        divisor0  = '0;
        dividend1 = '0;
        divisor1  = '0;

        // Reset state.
        tick();
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        // Client 0 alone, 65/3.
        d0 = done0_cnt;
        d1 = done1_cnt;
        run_op(1'b1, 1'b0, 16'd65, 16'd3, 16'd0, 16'd0, 1'b0);
        check("solo_done0_cnt", 32'(done0_cnt - d0), 32'd1);
        check("solo_done1_cnt", 32'(done1_cnt - d1), 32'd0);
        check("solo_dbus", 32'(div_dbus), 32'd65);
        check("solo_mbus", 32'(div_mbus), 32'd3);

        // Simultaneous requests straight after reset: client 0 first.
        do_reset();
        run_op(1'b1, 1'b1, 16'd15, 16'd3, 16'd113, 16'd10, 1'b0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Both clients hold their requests through four operations.
        tick();
        dividend0 = 16'd100;
        divisor0  = 16'd7;
        dividend1 = 16'd50;
        divisor1  = 16'd6;
        req0      = 1'b1;
        req1      = 1'b1;
        n         = 0;
        budget    = 0;
        while (n < 4 && budget < 600) begin
            tick();
            budget++;
            if (done0 || done1) begin
                c          = done1 ? 1 : 0;
                exp_c      = 1 - model_last;
                model_last = exp_c;
                check($sformatf("rr_order%0d", n), 32'(c), 32'(exp_c));
                check("rr_q", 32'(q_out), c ? 32'd8 : 32'd14);
                check("rr_r", 32'(r_out), c ? 32'd2 : 32'd2);
                n++;
                if (n == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        check("rr_count", 32'(n), 32'd4);

        // Zero divisor: no core start, done in the third cycle (IDLE, ZERO, DONE).
        run_op(1'b0, 1'b1, 16'd0, 16'd0, 16'd7, 16'd0, 1'b0);
        check("zero_latency", 32'(done_cyc - issue_cyc), 32'd2);

        // Hung core: abort exactly TIMEOUT cycles after the start pulse.
        hang = 1'b1;
        run_op(1'b1, 1'b0, 16'd9, 16'd2, 16'd0, 16'd0, 1'b1);
        check("timeout_latency", 32'(done_cyc - start_cyc), 32'(TIMEOUT));
        hang = 1'b0;
        run_op(1'b1, 1'b0, 16'd9, 16'd2, 16'd0, 16'd0, 1'b0);

        // Reset while waiting for the core.
        fixed_lat = 20;
        tick();
        dividend0 = 16'd65;
        divisor0  = 16'd3;
        req0      = 1'b1;
        s0        = start_cnt;
        budget    = 0;
        while (start_cnt == s0 && budget < 50) begin
            tick();
            budget++;
        end
        check("mid_start_seen", 32'(start_cnt != s0), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy", 32'(busy), 32'd1);
        d0 = done0_cnt;
        d1 = done1_cnt;
        req0 = 1'b0;
        rst  = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        tick();
        rst        = 1'b0;
        model_last = 1;
        for (int i = 0; i < 25; i++) tick();
        check("mid_no_done", 32'((done0_cnt - d0) + (done1_cnt - d1)), 32'd0);
        fixed_lat = 0;
        run_op(1'b1, 1'b0, 16'd65, 16'd3, 16'd0, 16'd0, 1'b0);

        // Randomized traffic against the arithmetic and round-robin model.
        for (int i = 0; i < 40; i++) begin
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            if (!rr0 && !rr1) rr0 = 1'b1;
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            rb0 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            rb1 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run_op(rr0, rr1, ra0, rb0, ra1, rb1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
